// File: rtl/tpu_host_ctrl_if.sv
// Host-side bundle of the TPU host controller: command intake, load stream,
// A/B buffer write ports, TPU launch handshake, C read port and result stream.
interface tpu_host_ctrl_if #(
   parameter int IDX_W = 16
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [7:0]        cmd_K;
   logic [7:0]        cmd_M;
   logic [7:0]        cmd_N;
   logic              ld_valid;
   logic              ld_ready;
   logic [31:0]       ld_data;
   logic              host_A_wr_en;
   logic [IDX_W-1:0]  host_A_index;
   logic [31:0]       host_A_data;
   logic              host_B_wr_en;
   logic [IDX_W-1:0]  host_B_index;
   logic [31:0]       host_B_data;
   logic              in_valid;
   logic [7:0]        K;
   logic [7:0]        M;
   logic [7:0]        N;
   logic              busy;
   logic [IDX_W-1:0]  host_C_index;
   logic [127:0]      host_C_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [127:0]      rd_data;
   logic              done;

   // Controller side
   modport slave (
      input  cmd_valid, cmd_K, cmd_M, cmd_N, ld_valid, ld_data, busy,
             host_C_data, rd_ready,
      output cmd_ready, ld_ready, host_A_wr_en, host_A_index, host_A_data,
             host_B_wr_en, host_B_index, host_B_data, in_valid, K, M, N,
             host_C_index, rd_valid, rd_data, done
   );

   // Host / TPU / buffer side
   modport master (
      output cmd_valid, cmd_K, cmd_M, cmd_N, ld_valid, ld_data, busy,
             host_C_data, rd_ready,
      input  cmd_ready, ld_ready, host_A_wr_en, host_A_index, host_A_data,
             host_B_wr_en, host_B_index, host_B_data, in_valid, K, M, N,
             host_C_index, rd_valid, rd_data, done
   );
endinterface

// File: rtl/tpu_host_ctrl.sv
// TPU host controller: accepts a K/M/N command, streams A then B words into
// the global buffers, launches the TPU, waits for busy to rise and fall, then
// reads the C buffer out one 128-bit word per rd handshake and pulses done.
module tpu_host_ctrl #(
   parameter int IDX_W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   tpu_host_ctrl_if.slave bus
);
   localparam int CNT_W = 16;

   typedef enum logic [3:0] {
      IDLE, LOAD_A, LOAD_B, START, WAIT_HI, WAIT_LO, READ_C, C_CAP, DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [CNT_W-1:0]  r_na;
   logic [CNT_W-1:0]  r_nb;
   logic [CNT_W-1:0]  r_nc;
   logic [CNT_W-1:0]  w_m4;
   logic [CNT_W-1:0]  w_n4;
   logic [7:0]        r_k;
   logic [7:0]        r_m;
   logic [7:0]        r_n;
   logic [127:0]      r_rd_data;
   logic              r_cap_first;
   logic              w_accept;
   logic              w_zero;

   assign w_accept = (r_state == IDLE) && bus.cmd_valid;
   assign w_zero   = (bus.cmd_K == 8'd0) || (bus.cmd_M == 8'd0) || (bus.cmd_N == 8'd0);
   // Rows/columns are packed four per word, so the dimensions round up to quads.
   assign w_m4     = (CNT_W'(bus.cmd_M) + CNT_W'(3)) >> 2;
   assign w_n4     = (CNT_W'(bus.cmd_N) + CNT_W'(3)) >> 2;

   // State and shared word counter register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Command capture: dimensions and derived word counts held until next accept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_k  <= '0;
         r_m  <= '0;
         r_n  <= '0;
         r_na <= '0;
         r_nb <= '0;
         r_nc <= '0;
      end else if (w_accept) begin
         r_k  <= bus.cmd_K;
         r_m  <= bus.cmd_M;
         r_n  <= bus.cmd_N;
         r_na <= w_m4 * CNT_W'(bus.cmd_K);
         r_nb <= w_n4 * CNT_W'(bus.cmd_K);
         r_nc <= w_n4 * CNT_W'(bus.cmd_M);
      end
   end

   // C word capture: the buffer answers one cycle after READ_C, i.e. during
   // the first C_CAP cycle; that word is forwarded and latched for the stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cap_first <= 1'b0;
         r_rd_data   <= '0;
      end else begin
         r_cap_first <= (r_state == READ_C);
         if (r_cap_first) begin
            r_rd_data <= bus.host_C_data;
         end
      end
   end

   // Next-state and counter logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (bus.cmd_valid) begin
               w_cnt_nxt   = '0;
               w_state_nxt = w_zero ? DONE : LOAD_A;
            end
         end
         LOAD_A: begin
            if (bus.ld_valid) begin
               if (r_cnt == r_na - CNT_W'(1)) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = LOAD_B;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         LOAD_B: begin
            if (bus.ld_valid) begin
               if (r_cnt == r_nb - CNT_W'(1)) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = START;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         START:   w_state_nxt = WAIT_HI;
         WAIT_HI: if (bus.busy) w_state_nxt = WAIT_LO;
         WAIT_LO: begin
            if (!bus.busy) begin
               w_cnt_nxt   = '0;
               w_state_nxt = READ_C;
            end
         end
         READ_C:  w_state_nxt = C_CAP;
         C_CAP: begin
            if (bus.rd_ready) begin
               if (r_cnt == r_nc - CNT_W'(1)) begin
                  w_state_nxt = DONE;
               end else begin
                  w_cnt_nxt   = r_cnt + CNT_W'(1);
                  w_state_nxt = READ_C;
               end
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.cmd_ready    = (r_state == IDLE);
   assign bus.ld_ready     = (r_state == LOAD_A) || (r_state == LOAD_B);
   assign bus.host_A_wr_en = (r_state == LOAD_A) && bus.ld_valid;
   assign bus.host_B_wr_en = (r_state == LOAD_B) && bus.ld_valid;
   assign bus.host_A_index = (r_state == LOAD_A) ? IDX_W'(r_cnt) : '0;
   assign bus.host_B_index = (r_state == LOAD_B) ? IDX_W'(r_cnt) : '0;
   assign bus.host_A_data  = bus.host_A_wr_en ? bus.ld_data : '0;
   assign bus.host_B_data  = bus.host_B_wr_en ? bus.ld_data : '0;
   assign bus.in_valid     = (r_state == START);
   assign bus.K            = r_k;
   assign bus.M            = r_m;
   assign bus.N            = r_n;
   assign bus.host_C_index = ((r_state == READ_C) || (r_state == C_CAP)) ? IDX_W'(r_cnt) : '0;
   assign bus.rd_valid     = (r_state == C_CAP);
   assign bus.rd_data      = ((r_state == C_CAP) && r_cap_first) ? bus.host_C_data : r_rd_data;
   assign bus.done         = (r_state == DONE);

endmodule

// File: tb/tb_tpu_host_ctrl.sv
// Bench for tpu_host_ctrl: directed and randomized jobs against a word-count
// and buffer reference model, with a TPU busy model and a registered C buffer.
module tb_tpu_host_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   tpu_host_ctrl_if #(.IDX_W(16)) bus();

   tpu_host_ctrl #(.IDX_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // C global buffer model: synchronous read, one cycle latency
   logic [127:0] cmem [0:63];
   always @(posedge clk) bus.host_C_data <= cmem[bus.host_C_index[5:0]];

   // Observed write traffic and strobe counts
   logic [47:0] a_wr [$];
   logic [47:0] b_wr [$];
   int n_in_valid, n_done, n_rdv, n_wr_bad;

   always @(negedge clk) begin
      if (bus.host_A_wr_en) a_wr.push_back({bus.host_A_index, bus.host_A_data});
      if (bus.host_B_wr_en) b_wr.push_back({bus.host_B_index, bus.host_B_data});
      if (bus.in_valid) n_in_valid++;
      if (bus.done) n_done++;
      if (bus.rd_valid) n_rdv++;
      if (((bus.host_A_wr_en | bus.host_B_wr_en) !== (bus.ld_valid & bus.ld_ready)) ||
          (bus.host_A_wr_en & bus.host_B_wr_en))
         n_wr_bad++;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      a_wr.delete();
      b_wr.delete();
      n_in_valid = 0;
      n_done     = 0;
      n_rdv      = 0;
      n_wr_bad   = 0;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
      chk({tag, "_strobes"}, {bus.ld_ready, bus.host_A_wr_en, bus.host_B_wr_en,
                              bus.in_valid, bus.rd_valid, bus.done}, 0);
      chk({tag, "_idx"}, {bus.host_A_index, bus.host_B_index, bus.host_C_index}, 0);
      chk({tag, "_data"}, {bus.host_A_data, bus.host_B_data}, 0);
      chk({tag, "_kmn"}, {bus.K, bus.M, bus.N}, 0);
      chk({tag, "_rd_data"}, bus.rd_data, 0);
   endtask

   task automatic do_cmd(input int k, input int m, input int n);
      int t = 0;
      @(negedge clk);
      while (!bus.cmd_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("cmd_ready_wait", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_K = 8'(k);
      bus.cmd_M = 8'(m);
      bus.cmd_N = 8'(n);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic run_job(input int k, input int m, input int n, input int gap,
                          input int stall_beat, input bit cmd_pulse, input bit do_reset);
      int na, nb, nc, t;
      logic [31:0]  words [$];
      logic [127:0] held;
      na = ((m + 3) / 4) * k;
      nb = ((n + 3) / 4) * k;
      nc = ((n + 3) / 4) * m;
      for (int i = 0; i < 64; i++) cmem[i] = {$urandom, $urandom, $urandom, $urandom};
      clear_mon();
      do_cmd(k, m, n);

      if (k == 0 || m == 0 || n == 0) begin
         @(negedge clk);
         chk("zero_done", bus.done, 1);
         @(negedge clk);
         chk("zero_back_idle", {bus.cmd_ready, bus.done}, 2'b10);
         chk("zero_wr_count", a_wr.size() + b_wr.size(), 0);
         chk("zero_in_valid", n_in_valid, 0);
         chk("zero_rd_valid", n_rdv, 0);
         chk("zero_done_count", n_done, 1);
         return;
      end

      // Load stream: all A words then all B words
      for (int w = 0; w < na + nb; w++) begin
         words.push_back($urandom);
         for (int g = 0; g < gap; g++) begin
            bus.ld_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         bus.ld_valid = 1'b1;
         bus.ld_data  = words[w];
         if (cmd_pulse && w == na + 1) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_K = 8'd7;
            bus.cmd_M = 8'd7;
            bus.cmd_N = 8'd7;
         end
         t = 0;
         @(negedge clk);
         while (!bus.ld_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         chk("ld_ready_wait", bus.ld_ready, 1);
         @(posedge clk);
         #1;
         bus.cmd_valid = 1'b0;
      end
      bus.ld_valid = 1'b0;

      // Launch
      t = 0;
      @(negedge clk);
      while (!bus.in_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("in_valid_seen", bus.in_valid, 1);
      chk("launch_kmn", {bus.K, bus.M, bus.N}, {8'(k), 8'(m), 8'(n)});

      // TPU busy model: rises two cycles after launch, high for five cycles
      repeat (2) @(posedge clk);
      #1;
      bus.busy = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      if (do_reset) begin
         rst_n = 1'b0;
         @(posedge clk);
         #1;
         rst_n = 1'b1;
         @(negedge clk);
         check_idle_outputs("wait_lo_reset");
         bus.busy = 1'b0;
         clear_mon();
         repeat (6) @(negedge clk);
         chk("post_reset_no_read", n_rdv, 0);
         chk("post_reset_c_idx", bus.host_C_index, 0);
         chk("post_reset_ready", bus.cmd_ready, 1);
         return;
      end
      bus.busy = 1'b0;

      // Readout
      for (int b = 0; b < nc; b++) begin
         t = 0;
         @(negedge clk);
         while (!bus.rd_valid && t < 20) begin
            @(negedge clk);
            t++;
         end
         chk("rd_valid", bus.rd_valid, 1);
         chk("rd_data", bus.rd_data, cmem[b]);
         chk("c_index", bus.host_C_index, 16'(b));
         if (b == stall_beat) begin
            held = bus.rd_data;
            repeat (10) begin
               @(negedge clk);
               chk("stall_hold", {bus.rd_valid, bus.host_C_index, bus.rd_data},
                   {1'b1, 16'(b), cmem[b]});
            end
         end
         #1;
         bus.rd_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.rd_ready = 1'b0;
      end

      t = 0;
      @(negedge clk);
      while (!bus.done && t < 10) begin
         @(negedge clk);
         t++;
      end
      chk("done_seen", bus.done, 1);
      @(negedge clk);
      chk("done_single", {bus.done, bus.cmd_ready}, 2'b01);
      chk("done_count", n_done, 1);
      chk("in_valid_count", n_in_valid, 1);
      chk("rd_valid_cycles", n_rdv >= nc, 1);
      chk("wr_only_on_hs", n_wr_bad, 0);
      chk("a_count", a_wr.size(), na);
      chk("b_count", b_wr.size(), nb);
      for (int i = 0; i < na && i < a_wr.size(); i++)
         chk("a_write", a_wr[i], {16'(i), words[i]});
      for (int i = 0; i < nb && i < b_wr.size(); i++)
         chk("b_write", b_wr[i], {16'(i), words[na + i]});
   endtask

   initial begin
      bus.cmd_valid   = 1'b0;
      bus.cmd_K       = '0;
      bus.cmd_M       = '0;
      bus.cmd_N       = '0;
      bus.ld_valid    = 1'b0;
      bus.ld_data     = '0;
      bus.busy        = 1'b0;
      bus.rd_ready    = 1'b0;
      for (int i = 0; i < 64; i++) cmem[i] = '0;
      clear_mon();

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset");

      run_job(2, 4, 4, 0, -1, 1'b0, 1'b0);   // basic 2x4x4
      run_job(3, 5, 1, 0, -1, 1'b0, 1'b0);   // NA=6, NB=3, NC=5
      run_job(0, 4, 4, 0, -1, 1'b0, 1'b0);   // zero dimension
      run_job(2, 4, 4, 0,  1, 1'b0, 1'b0);   // rd_ready stall mid-readout
      run_job(1, 4, 4, 0, -1, 1'b0, 1'b1);   // reset in WAIT_LO
      run_job(2, 4, 8, 3, -1, 1'b1, 1'b0);   // cmd in LOAD_B, ld gaps
      for (int r = 0; r < 4; r++)
         run_job(int'($urandom_range(1, 6)), int'($urandom_range(1, 12)),
                 int'($urandom_range(1, 12)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)), 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
